data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Memory responder serving the RV32I core's three memory ports: registered instruction fetch, combinational data read and byte-enabled data write. Holds a DEPTH-word RAM, aligns byte lanes from byte addresses, rejects misaligned and out-of-range accesses, and zero-fills itself after reset with a counter FSM before accepting traffic. Sits beside the core at top level, directly on its fetch/read/write buses.

## Interface
- ADDR_WIDTH, 31: MSB index of all address buses.
- DATA_WIDTH, 31: MSB index of all data buses. Only 31 is supported.
- DEPTH, 1024: number of 32-bit words. Must be a power of two, at least 4.

- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- clk_en  in  1  gates fetch, write and flag updates. Does not gate INIT.
- i_read_fetch_addr  in  ADDR_WIDTH+1  fetch address as a word index.
- o_read_fetch_data  out  DATA_WIDTH+1  registered instruction word.
- i_read_req  in  1  data read request.
- i_read_addr  in  ADDR_WIDTH+1  data read byte address.
- o_read_data  out  DATA_WIDTH+1  combinational, lane-shifted read data.
- i_write_enable  in  1  data write request.
- i_byte_enable  in  4  lane mask, LSB-justified (0001 byte, 0011 half, 1111 word).
- i_write_addr  in  ADDR_WIDTH+1  data write byte address.
- i_write_data  in  DATA_WIDTH+1  LSB-justified write data.
- o_busy  out  1  high while INIT is running.
- o_misaligned  out  1  one-cycle pulse: the previous enabled edge saw a misaligned access.
- o_out_of_range  out  1  one-cycle pulse: the previous enabled edge saw an access with index ≥ DEPTH.

## Operation
- **FSM:** two states, INIT and READY.
  - Reset forces INIT with clr_cnt=0.
  - In INIT, each clk edge writes 0 to mem[clr_cnt] and increments clr_cnt. This ignores clk_en.
  - At clr_cnt==DEPTH-1 the FSM enters READY on the same edge.
  - o_busy = (state==INIT).
  - READY is terminal until the next reset.
- **Address decode:** for data ports, idx = addr[ADDR_WIDTH:2] and off = addr[1:0]. For fetch, idx = i_read_fetch_addr.
- **Lane shift:** shifted mask = {4'b0, i_byte_enable} << off.
- **Misaligned:** the shifted mask has any bit set in [7:4] (e.g. word at off≠0, half at off=3).
- **Out of range:** idx ≥ DEPTH.
- **Write:** on an edge with READY, clk_en, i_write_enable, in range and aligned:
  - lane k of mem[idx] takes byte (k-off) of i_write_data wherever shifted mask bit k is set.
  - Other lanes are unchanged.
  - A rejected write changes no memory.
- **Data read (combinational):** o_read_data = mem[idx] >> (8*off) when READY, i_read_req set, in range and aligned. Otherwise it is 0. The core sign/zero-extends from the low bits.
- **Fetch (registered):** on an edge with clk_en:
  - o_read_fetch_data <= mem[idx] if READY and in range, else 0.
  - Write-first: if a write to the same word commits on that edge, return the post-write word.
- **Flags:** on each clk_en edge, o_misaligned and o_out_of_range <= the OR of the conditions from the active read (i_read_req) and the active write. They are cleared on the next clk_en edge without the condition. Fetch out-of-range also sets o_out_of_range.
- **Simultaneous read and write to the same word:** the combinational read shows the pre-edge contents. The write lands at the edge.

## Timing
- Reset values: o_read_fetch_data=0, o_busy=1, o_misaligned=0, o_out_of_range=0, state=INIT, clr_cnt=0.
- o_busy falls exactly DEPTH rising edges after rst_n deasserts.
- Fetch latency: 1 enabled cycle. Data read latency: 0 cycles (combinational).
- Write visibility:
  - data read: the cycle after the edge.
  - fetch: the same edge (forwarded).
- clk_en low: fetch register, memory (outside INIT) and flags all hold.
- Reset mid-INIT or mid-traffic: immediate return to INIT, clr_cnt=0, outputs to their reset values. Memory is zero-filled again.
- Accesses during INIT: writes are dropped, reads return 0, fetch returns 0. Flags do not update.

## Test plan
- **Reset/INIT, DEPTH=16:** release rst_n, then o_busy=1 for 16 edges and falls on the 16th. Fetch of every index 0..15 then returns 0.
- **Byte store:** write data 0x000000AB, mask 0001 to byte addr 0x6. Read byte addr 0x4 → 0x00AB0000. Read byte addr 0x6 → 0x000000AB.
- **Write-first fetch:**
  - Setup: word 3 = 0x11111111. Write 0xDEADBEEF mask 1111 to byte addr 0xC while fetching index 3.
  - Expected: o_read_fetch_data=0xDEADBEEF the next cycle.
- **Misaligned:**
  - Setup: word 1 = 0x12345678. Word write to byte addr 0x5, or half write to 0x7.
  - Expected: memory unchanged (word 1 still 0x12345678). o_misaligned pulses for exactly one cycle.
- **Out of range:** DEPTH=16, write word to byte addr 0x40 → no memory change, o_out_of_range pulse. Read of 0x40 → o_read_data=0.
- **clk_en and reset:**
  - clk_en=0 with a write: word unchanged, fetch output holds.
  - rst_n asserted at INIT count 5: o_busy stays high, INIT restarts, o_busy falls 16 edges after release.

Source files
------------

// File: rtl/data_mem_responder.sv
// Byte-lane RAM serving the core's fetch, data-read and data-write ports.
// Zero-fills itself after reset, then serves traffic with alignment and range checks.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 31,
  parameter int DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic [ADDR_WIDTH:0]   i_read_fetch_addr,
  output logic [DATA_WIDTH:0]   o_read_fetch_data,
  input  logic                  i_read_req,
  input  logic [ADDR_WIDTH:0]   i_read_addr,
  output logic [DATA_WIDTH:0]   o_read_data,
  input  logic                  i_write_enable,
  input  logic [3:0]            i_byte_enable,
  input  logic [ADDR_WIDTH:0]   i_write_addr,
  input  logic [DATA_WIDTH:0]   i_write_data,
  output logic                  o_busy,
  output logic                  o_misaligned,
  output logic                  o_out_of_range
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [IDX_W-1:0]    clr_cnt_q, clr_cnt_d;
  logic [DATA_WIDTH:0] fetch_q, fetch_d;
  logic                mis_q, mis_d;
  logic                oor_q, oor_d;

  logic ready;
  assign ready = (state_q == ST_READY);

  // Address decode: data ports are byte addressed, fetch is word addressed
  logic [IDX_W-1:0] rd_idx, wr_idx, fe_idx;
  logic [1:0]       rd_off, wr_off;
  logic             rd_oor, wr_oor, fe_oor;
  logic [7:0]       rd_mask_sh, wr_mask_sh;
  logic             rd_mis, wr_mis;

  assign rd_idx = i_read_addr[IDX_W+1:2];
  assign wr_idx = i_write_addr[IDX_W+1:2];
  assign fe_idx = i_read_fetch_addr[IDX_W-1:0];
  assign rd_off = i_read_addr[1:0];
  assign wr_off = i_write_addr[1:0];
  assign rd_oor = |i_read_addr[ADDR_WIDTH:IDX_W+2];
  assign wr_oor = |i_write_addr[ADDR_WIDTH:IDX_W+2];
  assign fe_oor = |i_read_fetch_addr[ADDR_WIDTH:IDX_W];

  // Reads take their access size from the same byte-enable mask as writes
  assign rd_mask_sh = {4'b0000, i_byte_enable} << rd_off;
  assign wr_mask_sh = {4'b0000, i_byte_enable} << wr_off;
  assign rd_mis     = |rd_mask_sh[7:4];
  assign wr_mis     = |wr_mask_sh[7:4];

  logic                wr_commit;
  logic [DATA_WIDTH:0] wr_data_sh;
  assign wr_commit  = ready & clk_en & i_write_enable & ~wr_oor & ~wr_mis;
  assign wr_data_sh = i_write_data << {wr_off, 3'b000};

  logic [DATA_WIDTH:0] rd_word;
  logic [DATA_WIDTH:0] fe_word;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0]       mem [DEPTH];
    logic             lane_we;
    logic             lane_wr_hit;
    logic [IDX_W-1:0] lane_waddr;
    logic [7:0]       lane_wbyte;

    assign lane_wr_hit = wr_commit & wr_mask_sh[gi];

    always_comb begin
      lane_we    = 1'b0;
      lane_waddr = wr_idx;
      lane_wbyte = wr_data_sh[8*gi +: 8];
      if (state_q == ST_INIT) begin
        lane_we    = 1'b1;
        lane_waddr = clr_cnt_q;
        lane_wbyte = 8'h00;
      end else if (lane_wr_hit) begin
        lane_we    = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (lane_we) begin
        mem[lane_waddr] <= lane_wbyte;
      end
    end

    assign rd_word[8*gi +: 8] = mem[rd_idx];
    // Fetch forwards a same-edge write so the core sees the post-write word
    assign fe_word[8*gi +: 8] = (lane_wr_hit && (wr_idx == fe_idx)) ? lane_wbyte : mem[fe_idx];
  end

  assign o_read_data = (ready && i_read_req && !rd_oor && !rd_mis)
                     ? (rd_word >> {rd_off, 3'b000}) : '0;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    fetch_d   = fetch_q;
    mis_d     = mis_q;
    oor_d     = oor_q;
    if (state_q == ST_INIT) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == LAST_IDX) begin
        state_d = ST_READY;
      end
    end
    if (clk_en) begin
      fetch_d = (ready && !fe_oor) ? fe_word : '0;
      if (ready) begin
        mis_d = (i_read_req & rd_mis) | (i_write_enable & wr_mis);
        oor_d = (i_read_req & rd_oor) | (i_write_enable & wr_oor) | fe_oor;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      clr_cnt_q <= '0;
      fetch_q   <= '0;
      mis_q     <= 1'b0;
      oor_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      fetch_q   <= fetch_d;
      mis_q     <= mis_d;
      oor_q     <= oor_d;
    end
  end

  assign o_read_fetch_data = fetch_q;
  assign o_busy            = (state_q == ST_INIT);
  assign o_misaligned      = mis_q;
  assign o_out_of_range    = oor_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder (DEPTH=16) against a byte-addressed reference model.
module tb_data_mem_responder;

  localparam int DEPTH = 16;
  localparam int NBYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b1;
  logic [31:0] fetch_addr = '0;
  logic [31:0] fetch_data;
  logic        read_req = 1'b0;
  logic [31:0] read_addr = '0;
  logic [31:0] read_data;
  logic        we = 1'b0;
  logic [3:0]  be = 4'hF;
  logic [31:0] write_addr = '0;
  logic [31:0] write_data = '0;
  logic        busy, mis, oor;

  int n_cmp = 0;
  int n_err = 0;
  int n_txn = 0;

  // Reference model: flat byte memory plus expected registered outputs
  logic [7:0]  ref_mem [NBYTES];
  bit          ref_ready;
  int          init_edges;
  logic [31:0] exp_fetch;
  logic        exp_mis, exp_oor;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_WIDTH(31), .DATA_WIDTH(31), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .i_read_fetch_addr(fetch_addr), .o_read_fetch_data(fetch_data),
    .i_read_req(read_req), .i_read_addr(read_addr), .o_read_data(read_data),
    .i_write_enable(we), .i_byte_enable(be), .i_write_addr(write_addr),
    .i_write_data(write_data), .o_busy(busy), .o_misaligned(mis),
    .o_out_of_range(oor)
  );

  function automatic bit ref_mis(input logic [31:0] a, input logic [3:0] m);
    for (int k = 0; k < 4; k++)
      if (m[k] && (int'(a[1:0]) + k) > 3) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_word(input int base);
    return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [3:0] m);
    logic [31:0] r = '0;
    if (ref_ready && a < NBYTES && !ref_mis(a, m))
      for (int j = 0; j < 4 - int'(a[1:0]); j++) r[8*j +: 8] = ref_mem[int'(a) + j];
    return r;
  endfunction

  task automatic reset_model();
    ref_ready  = 1'b0;
    init_edges = 0;
    exp_fetch  = '0;
    exp_mis    = 1'b0;
    exp_oor    = 1'b0;
    for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
  endtask

  task automatic ref_edge();
    if (!ref_ready) begin
      init_edges++;
      if (init_edges == DEPTH) ref_ready = 1'b1;
      if (clk_en) exp_fetch = '0;
    end else if (clk_en) begin
      exp_mis = (read_req && ref_mis(read_addr, be)) || (we && ref_mis(write_addr, be));
      exp_oor = (read_req && read_addr >= NBYTES) || (we && write_addr >= NBYTES) ||
                (fetch_addr >= DEPTH);
      if (we && write_addr < NBYTES && !ref_mis(write_addr, be))
        for (int k = 0; k < 4; k++)
          if (be[k]) ref_mem[int'(write_addr) + k] = write_data[8*k +: 8];
      exp_fetch = (fetch_addr < DEPTH) ? ref_word(int'(fetch_addr) * 4) : '0;
    end
  endtask

  task automatic step();
    n_txn++;
    $display("txn %0d: en=%0b we=%0b wa=%h wd=%h be=%h rr=%0b ra=%h fa=%0d",
             n_txn, clk_en, we, write_addr, write_data, be, read_req, read_addr, fetch_addr);
    ref_edge();
    @(negedge clk);
  endtask

  task automatic set_idle();
    clk_en = 1'b1; we = 1'b0; read_req = 1'b0; be = 4'hF;
    fetch_addr = '0; write_addr = '0; read_addr = '0; write_data = '0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    we = 1'b1; write_addr = a; write_data = d; be = m;
    step();
    we = 1'b0; be = 4'hF;
  endtask

  task automatic test_reset();
    int edges = 0;
    set_idle();
    rst_n = 1'b0;
    reset_model();
    @(negedge clk); @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b expected 1", busy); end
    n_cmp++; if (fetch_data !== 32'h0) begin n_err++; $display("FAIL reset_fetch: got %h expected 0", fetch_data); end
    n_cmp++; if (mis !== 1'b0 || oor !== 1'b0) begin n_err++; $display("FAIL reset_flags: got %b%b expected 00", mis, oor); end
    rst_n = 1'b1;
    // Traffic during INIT must be dropped
    we = 1'b1; write_addr = 32'h0; write_data = 32'hCAFEF00D;
    read_req = 1'b1; read_addr = 32'h0; fetch_addr = 32'd3;
    for (int i = 0; i < 40 && busy; i++) begin
      #1;
      n_cmp++; if (read_data !== 32'h0) begin n_err++; $display("FAIL init_read: got %h expected 0", read_data); end
      step();
      edges++;
      n_cmp++; if (busy !== !ref_ready) begin n_err++; $display("FAIL init_busy: got %b expected %b at edge %0d", busy, !ref_ready, edges); end
      n_cmp++; if (fetch_data !== exp_fetch) begin n_err++; $display("FAIL init_fetch: got %h expected %h", fetch_data, exp_fetch); end
    end
    n_cmp++; if (edges !== DEPTH) begin n_err++; $display("FAIL init_length: got %0d expected %0d", edges, DEPTH); end
    set_idle();
    for (int i = 0; i < DEPTH; i++) begin
      fetch_addr = i;
      step();
      n_cmp++; if (fetch_data !== 32'h0) begin n_err++; $display("FAIL fetch_zero[%0d]: got %h expected 0", i, fetch_data); end
    end
  endtask

  task automatic test_byte_store();
    set_idle();
    do_write(32'h6, 32'h000000AB, 4'b0001);
    read_req = 1'b1; read_addr = 32'h4; be = 4'hF; #1;
    n_cmp++; if (read_data !== 32'h00AB0000) begin n_err++; $display("FAIL byte_read4: got %h expected 00ab0000", read_data); end
    read_addr = 32'h6; be = 4'b0001; #1;
    n_cmp++; if (read_data !== 32'h000000AB) begin n_err++; $display("FAIL byte_read6: got %h expected 000000ab", read_data); end
    step();
  endtask

  task automatic test_write_first();
    set_idle();
    do_write(32'hC, 32'h11111111, 4'hF);
    we = 1'b1; write_addr = 32'hC; write_data = 32'hDEADBEEF; be = 4'hF;
    fetch_addr = 32'd3; read_req = 1'b1; read_addr = 32'hC; #1;
    n_cmp++; if (read_data !== 32'h11111111) begin n_err++; $display("FAIL wf_pre_read: got %h expected 11111111", read_data); end
    step();
    n_cmp++; if (fetch_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL wf_fetch: got %h expected deadbeef", fetch_data); end
    set_idle();
    read_req = 1'b1; read_addr = 32'hC; #1;
    n_cmp++; if (read_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL wf_post_read: got %h expected deadbeef", read_data); end
    step();
  endtask

  task automatic test_misaligned();
    logic [31:0] bad_addr [2] = '{32'h5, 32'h7};
    logic [3:0]  bad_mask [2] = '{4'b1111, 4'b0011};
    set_idle();
    do_write(32'h4, 32'h12345678, 4'hF);
    for (int i = 0; i < 2; i++) begin
      do_write(bad_addr[i], $urandom, bad_mask[i]);
      n_cmp++; if (mis !== 1'b1) begin n_err++; $display("FAIL mis_pulse[%0d]: got %b expected 1", i, mis); end
      step();
      n_cmp++; if (mis !== 1'b0) begin n_err++; $display("FAIL mis_clear[%0d]: got %b expected 0", i, mis); end
      read_req = 1'b1; read_addr = 32'h4; #1;
      n_cmp++; if (read_data !== 32'h12345678) begin n_err++; $display("FAIL mis_nowrite[%0d]: got %h expected 12345678", i, read_data); end
      read_req = 1'b0;
    end
  endtask

  task automatic test_out_of_range();
    set_idle();
    do_write(32'h40, $urandom, 4'hF);
    n_cmp++; if (oor !== 1'b1 || mis !== 1'b0) begin n_err++; $display("FAIL oor_write: got %b%b expected 10", oor, mis); end
    step();
    n_cmp++; if (oor !== 1'b0) begin n_err++; $display("FAIL oor_clear: got %b expected 0", oor); end
    read_req = 1'b1; read_addr = 32'h40; #1;
    n_cmp++; if (read_data !== 32'h0) begin n_err++; $display("FAIL oor_read: got %h expected 0", read_data); end
    step();
    n_cmp++; if (oor !== 1'b1) begin n_err++; $display("FAIL oor_read_flag: got %b expected 1", oor); end
    read_req = 1'b0; fetch_addr = DEPTH;
    step();
    n_cmp++; if (oor !== 1'b1 || fetch_data !== 32'h0) begin n_err++; $display("FAIL oor_fetch: got %b/%h expected 1/0", oor, fetch_data); end
    set_idle();
    read_req = 1'b1; read_addr = 32'h0; #1;
    n_cmp++; if (read_data !== ref_read(32'h0, 4'hF)) begin n_err++; $display("FAIL oor_alias: got %h expected %h", read_data, ref_read(32'h0, 4'hF)); end
    step();
  endtask

  task automatic test_clk_en();
    set_idle();
    fetch_addr = 32'd1;
    do_write(32'h5, 32'hFFFFFFFF, 4'hF);
    n_cmp++; if (fetch_data !== 32'h12345678 || mis !== 1'b1) begin n_err++; $display("FAIL ce_setup: got %h/%b expected 12345678/1", fetch_data, mis); end
    clk_en = 1'b0; fetch_addr = 32'd2;
    do_write(32'h4, 32'hA5A5A5A5, 4'hF);
    n_cmp++; if (fetch_data !== 32'h12345678) begin n_err++; $display("FAIL ce_fetch_hold: got %h expected 12345678", fetch_data); end
    n_cmp++; if (mis !== 1'b1) begin n_err++; $display("FAIL ce_flag_hold: got %b expected 1", mis); end
    set_idle();
    read_req = 1'b1; read_addr = 32'h4; #1;
    n_cmp++; if (read_data !== 32'h12345678) begin n_err++; $display("FAIL ce_nowrite: got %h expected 12345678", read_data); end
    step();
  endtask

  task automatic test_random();
    logic [31:0] exp_rd;
    for (int i = 0; i < 200; i++) begin
      clk_en     = ($urandom_range(0, 7) != 0);
      we         = 1'($urandom_range(0, 1));
      read_req   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: be = 4'b0001;
        1: be = 4'b0011;
        2: be = 4'b1111;
        default: be = 4'($urandom_range(1, 15));
      endcase
      write_addr = $urandom_range(0, NBYTES + 7);
      read_addr  = $urandom_range(0, NBYTES + 7);
      fetch_addr = $urandom_range(0, DEPTH);
      write_data = $urandom;
      #1;
      exp_rd = read_req ? ref_read(read_addr, be) : 32'h0;
      n_cmp++; if (read_data !== exp_rd) begin n_err++; $display("FAIL rnd_read[%0d]: got %h expected %h", i, read_data, exp_rd); end
      step();
      n_cmp++; if (fetch_data !== exp_fetch) begin n_err++; $display("FAIL rnd_fetch[%0d]: got %h expected %h", i, fetch_data, exp_fetch); end
      n_cmp++; if (mis !== exp_mis || oor !== exp_oor) begin n_err++; $display("FAIL rnd_flags[%0d]: got %b%b expected %b%b", i, mis, oor, exp_mis, exp_oor); end
    end
  endtask

  task automatic test_reset_mid_init();
    int edges = 0;
    set_idle();
    rst_n = 1'b0;
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy: got %b expected 1", busy); end
    rst_n = 1'b0;
    reset_model();
    #1;
    n_cmp++; if (busy !== 1'b1 || fetch_data !== 32'h0 || mis !== 1'b0 || oor !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_vals: got %b/%h/%b%b expected 1/0/00", busy, fetch_data, mis, oor);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40 && busy; i++) begin
      step();
      edges++;
    end
    n_cmp++; if (edges !== DEPTH) begin n_err++; $display("FAIL mid_init_length: got %0d expected %0d", edges, DEPTH); end
    read_req = 1'b1; be = 4'hF;
    for (int i = 0; i < DEPTH; i++) begin
      read_addr = i * 4; #1;
      n_cmp++; if (read_data !== 32'h0) begin n_err++; $display("FAIL refill[%0d]: got %h expected 0", i, read_data); end
    end
    set_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_byte_store();
    test_write_first();
    test_misaligned();
    test_out_of_range();
    test_clk_en();
    test_random();
    test_reset_mid_init();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
